// File: rtl/multi_channel_data_mover_pkg.sv
// -----------------------------------------------------------------------------
// multi_channel_data_mover_pkg
// Shared types and helpers for the multi-channel data mover:
//   flit_t        - one packet-buffer word: 512-bit data, sop, eop, 6-bit empty
//   state_t       - mover control states
//   sel_width()   - width of a select field for n alternatives (min 1 bit)
// -----------------------------------------------------------------------------
package multi_channel_data_mover_pkg;

    localparam int DATA_W  = 512;
    localparam int EMPTY_W = 6;
    localparam int FLIT_BITS = DATA_W + 2 + EMPTY_W;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } flit_t;

    typedef enum logic [1:0] {
        WAIT_STABLE = 2'd0,
        INIT        = 2'd1,
        IDLE        = 2'd2,
        READ        = 2'd3
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_channel_data_mover_out_fifo.sv
// -----------------------------------------------------------------------------
// mover_out_fifo
// First-word-fall-through FIFO holding flits for one output channel.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_wr/i_wdata  write strobe and flit
//   i_rd          consumer accepted the head flit (ignored when empty)
//   o_rdata       head flit (all zero when empty)
//   o_empty       FIFO holds no flit
// Overflow is prevented upstream by the channel credit counter.
// -----------------------------------------------------------------------------
module mover_out_fifo
    import multi_channel_data_mover_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_wr,
    input  flit_t i_wdata,
    input  logic  i_rd,
    output flit_t o_rdata,
    output logic  o_empty
);
    localparam int AW = $clog2(DEPTH);

    flit_t       r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_rd    = i_rd & ~o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Storage array, no reset needed: reads are gated by the pointers.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Read/write pointers with one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/multi_channel_data_mover.sv
// -----------------------------------------------------------------------------
// multi_channel_data_mover
// Drains packets from the packet buffer to one of NUM_CH output streams
// chosen per packet, with per-channel credit backpressure, and initialises /
// refills the packet-slot emptylist.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   meta_valid/ready, pktid/flits/dst/drop   scheduler metadata handshake
//   pkt_buffer_address/read             buffer read request
//   pkt_buffer_readvalid/readdata       buffer read return (fixed latency)
//   emptylist_in_data/valid/ready       freed-slot push
//   out_valid/ready/sop/eop/data/empty  per-channel output streams
// Optional feature macro DATA_MOVER_STATS_EN adds stat_pkt_cnt (per channel
// completed packets) and stat_drop_cnt. SIM adds protocol-error traps.
// -----------------------------------------------------------------------------
module multi_channel_data_mover
    import multi_channel_data_mover_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int PKT_NUM       = 512,
    parameter int MAX_FLITS     = 32,
    parameter int PKT_AWIDTH    = $clog2(PKT_NUM),
    parameter int FLIT_W        = $clog2(MAX_FLITS),
    parameter int PKTBUF_AWIDTH = PKT_AWIDTH + FLIT_W,
    parameter int RD_LATENCY    = 12,
    parameter int OUT_DEPTH     = 16,
    parameter int INIT_WAIT     = 50,
    parameter int DST_W         = sel_width(NUM_CH)
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      meta_valid,
    output logic                      meta_ready,
    input  logic [PKT_AWIDTH-1:0]     meta_pktid,
    input  logic [FLIT_W:0]           meta_flits,
    input  logic [DST_W-1:0]          meta_dst,
    input  logic                      meta_drop,
    output logic [PKTBUF_AWIDTH-1:0]  pkt_buffer_address,
    output logic                      pkt_buffer_read,
    input  logic                      pkt_buffer_readvalid,
    input  flit_t                     pkt_buffer_readdata,
    output logic [PKT_AWIDTH-1:0]     emptylist_in_data,
    output logic                      emptylist_in_valid,
    input  logic                      emptylist_in_ready,
    output logic [NUM_CH-1:0]         out_valid,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [NUM_CH-1:0]         out_sop,
    output logic [NUM_CH-1:0]         out_eop,
    output logic [NUM_CH*DATA_W-1:0]  out_data,
    output logic [NUM_CH*EMPTY_W-1:0] out_empty
`ifdef DATA_MOVER_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]      stat_pkt_cnt,
    output logic [31:0]               stat_drop_cnt
`endif
);
    localparam int CW     = $clog2(OUT_DEPTH) + 1;
    localparam int WAIT_W = $clog2(INIT_WAIT + 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [WAIT_W-1:0]       r_wait_cnt;
    logic [PKT_AWIDTH-1:0]   r_pktid;
    logic [FLIT_W:0]         r_flits;
    logic [FLIT_W-1:0]       r_idx;
    logic [DST_W-1:0]        r_dst;
    logic                    r_el_valid;
    logic [PKT_AWIDTH-1:0]   r_el_data;
    logic                    r_pend_valid;
    logic [PKT_AWIDTH-1:0]   r_pend_data;
    logic [RD_LATENCY-1:0]   r_tag_vld;
    logic [DST_W-1:0]        r_tag_dst [RD_LATENCY];
    logic [CW-1:0]           w_credit [NUM_CH];

    logic w_el_free, w_credit_ok, w_last, w_issue, w_push_last;
    logic w_meta_ready, w_accept, w_wait_done;

    // Output register can take a new push when empty or being drained now.
    assign w_el_free   = ~r_el_valid | emptylist_in_ready;
    assign w_credit_ok = w_credit[r_dst] < CW'(OUT_DEPTH);
    assign w_last      = ({1'b0, r_idx} == (r_flits - {{FLIT_W{1'b0}}, 1'b1}));
    // The last flit waits for a free emptylist slot so its push is never lost.
    assign w_issue     = (r_state == READ) & w_credit_ok & (~w_last | w_el_free);
    assign w_push_last = w_issue & w_last;
    assign w_accept    = meta_valid & w_meta_ready;
    assign w_wait_done = (r_wait_cnt == WAIT_W'(INIT_WAIT - 1));

    assign meta_ready         = w_meta_ready;
    assign pkt_buffer_read    = w_issue;
    assign pkt_buffer_address = {r_pktid, r_idx};
    assign emptylist_in_valid = r_el_valid;
    assign emptylist_in_data  = r_el_data;

    // Metadata acceptance window.
    always_comb begin
        w_meta_ready = 1'b0;
        case (r_state)
            IDLE:    w_meta_ready = w_el_free & ~r_pend_valid;
            READ:    w_meta_ready = w_push_last & ~r_pend_valid;
            default: w_meta_ready = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_STABLE: begin
                if (w_wait_done) w_next_state = INIT;
                else             w_next_state = WAIT_STABLE;
            end
            INIT: begin
                if (emptylist_in_ready && (r_el_data == PKT_AWIDTH'(PKT_NUM - 1))) w_next_state = IDLE;
                else                                                               w_next_state = INIT;
            end
            IDLE: begin
                if (w_accept && !meta_drop) w_next_state = READ;
                else                        w_next_state = IDLE;
            end
            READ: begin
                if (w_push_last && !(w_accept && !meta_drop)) w_next_state = IDLE;
                else                                          w_next_state = READ;
            end
            default: w_next_state = WAIT_STABLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT_STABLE;
        else        r_state <= w_next_state;
    end

    // Settle counter, emptylist push register and packet context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt   <= '0;
            r_el_valid   <= 1'b0;
            r_el_data    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_pktid      <= '0;
            r_flits      <= '0;
            r_idx        <= '0;
            r_dst        <= '0;
        end else begin
            case (r_state)
                WAIT_STABLE: begin
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    if (w_wait_done) begin
                        r_el_valid <= 1'b1;
                        r_el_data  <= '0;
                    end
                end
                INIT: begin
                    if (emptylist_in_ready) begin
                        if (r_el_data == PKT_AWIDTH'(PKT_NUM - 1)) r_el_valid <= 1'b0;
                        else r_el_data <= r_el_data + PKT_AWIDTH'(1);
                    end
                end
                default: begin
                    if (w_push_last) begin
                        r_el_valid <= 1'b1;
                        r_el_data  <= r_pktid;
                        // A drop accepted alongside the last flit queues behind it.
                        if (w_accept && meta_drop) begin
                            r_pend_valid <= 1'b1;
                            r_pend_data  <= meta_pktid;
                        end
                    end else if (w_accept && meta_drop) begin
                        r_el_valid <= 1'b1;
                        r_el_data  <= meta_pktid;
                    end else if (w_el_free) begin
                        r_el_valid   <= r_pend_valid;
                        r_el_data    <= r_pend_valid ? r_pend_data : r_el_data;
                        r_pend_valid <= 1'b0;
                    end
                end
            endcase
            if (w_accept && !meta_drop) begin
                r_pktid <= meta_pktid;
                r_flits <= meta_flits;
                r_dst   <= meta_dst;
                r_idx   <= '0;
            end else if (w_issue) begin
                r_idx <= r_idx + FLIT_W'(1);
            end
        end
    end

    // Tag pipe tracking destination of every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) r_tag_dst[i] <= '0;
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_dst[0] <= r_dst;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_dst[i] <= r_tag_dst[i-1];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CW-1:0] r_credit;
        logic          w_inc, w_dec, w_wr, w_empty;
        flit_t         w_head;

        assign w_inc = w_issue & (r_dst == DST_W'(c));
        assign w_dec = out_valid[c] & out_ready[c];
        assign w_wr  = pkt_buffer_readvalid & r_tag_vld[RD_LATENCY-1]
                     & (r_tag_dst[RD_LATENCY-1] == DST_W'(c));
        assign w_credit[c] = r_credit;

        // Credit = FIFO occupancy plus reads still in flight to this channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)              r_credit <= '0;
            else if (w_inc && !w_dec) r_credit <= r_credit + CW'(1);
            else if (w_dec && !w_inc) r_credit <= r_credit - CW'(1);
            else                      r_credit <= r_credit;
        end

        mover_out_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_wr    (w_wr),
            .i_wdata (pkt_buffer_readdata),
            .i_rd    (out_ready[c]),
            .o_rdata (w_head),
            .o_empty (w_empty)
        );

        assign out_valid[c]                    = ~w_empty;
        assign out_sop[c]                      = w_head.sop;
        assign out_eop[c]                      = w_head.eop;
        assign out_data[c*DATA_W +: DATA_W]    = w_head.data;
        assign out_empty[c*EMPTY_W +: EMPTY_W] = w_head.empty;

`ifdef DATA_MOVER_STATS_EN
        logic [31:0] r_pkt_cnt;
        // Completed packets on this channel, wrapping at 2^32.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                 r_pkt_cnt <= 32'd0;
            else if (w_dec && out_eop[c]) r_pkt_cnt <= r_pkt_cnt + 32'd1;
            else                        r_pkt_cnt <= r_pkt_cnt;
        end
        assign stat_pkt_cnt[c*32 +: 32] = r_pkt_cnt;
`endif
    end

`ifdef DATA_MOVER_STATS_EN
    logic [31:0] r_drop_cnt;
    // Dropped packets, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_drop_cnt <= 32'd0;
        else if (w_accept && meta_drop) r_drop_cnt <= r_drop_cnt + 32'd1;
        else                            r_drop_cnt <= r_drop_cnt;
    end
    assign stat_drop_cnt = r_drop_cnt;
`endif

`ifdef SIM
    // Protocol-error traps for simulation builds.
    always_ff @(posedge clk) begin
        if (rst_n && pkt_buffer_readvalid && !r_tag_vld[RD_LATENCY-1])
            $fatal(1, "readvalid without matching read tag");
        if (rst_n && w_accept && !meta_drop
            && ((meta_flits == '0) || (meta_flits > (FLIT_W+1)'(MAX_FLITS))))
            $fatal(1, "meta_flits out of range");
    end
`endif

endmodule

// File: tb/tb_multi_channel_data_mover.sv
module tb_multi_channel_data_mover;
    import multi_channel_data_mover_pkg::*;

    localparam int NUM_CH     = 2;
    localparam int PKT_NUM    = 512;
    localparam int MAX_FLITS  = 32;
    localparam int PKT_AW     = $clog2(PKT_NUM);
    localparam int FLIT_W     = $clog2(MAX_FLITS);
    localparam int PB_AW      = PKT_AW + FLIT_W;
    localparam int RD_LATENCY = 12;
    localparam int OUT_DEPTH  = 16;
    localparam int INIT_WAIT  = 50;
    localparam int DST_W      = sel_width(NUM_CH);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     meta_valid, meta_ready, meta_drop;
    logic [PKT_AW-1:0]        meta_pktid;
    logic [FLIT_W:0]          meta_flits;
    logic [DST_W-1:0]         meta_dst;
    logic [PB_AW-1:0]         pkt_buffer_address;
    logic                     pkt_buffer_read, pkt_buffer_readvalid;
    flit_t                    pkt_buffer_readdata;
    logic [PKT_AW-1:0]        emptylist_in_data;
    logic                     emptylist_in_valid, emptylist_in_ready;
    logic [NUM_CH-1:0]        out_valid, out_ready, out_sop, out_eop;
    logic [NUM_CH*512-1:0]    out_data;
    logic [NUM_CH*6-1:0]      out_empty;
`ifdef DATA_MOVER_STATS_EN
    logic [NUM_CH*32-1:0]     stat_pkt_cnt;
    logic [31:0]              stat_drop_cnt;
`endif

    multi_channel_data_mover #(
        .NUM_CH(NUM_CH), .PKT_NUM(PKT_NUM), .MAX_FLITS(MAX_FLITS),
        .RD_LATENCY(RD_LATENCY), .OUT_DEPTH(OUT_DEPTH), .INIT_WAIT(INIT_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_pktid(meta_pktid),
        .meta_flits(meta_flits), .meta_dst(meta_dst), .meta_drop(meta_drop),
        .pkt_buffer_address(pkt_buffer_address), .pkt_buffer_read(pkt_buffer_read),
        .pkt_buffer_readvalid(pkt_buffer_readvalid), .pkt_buffer_readdata(pkt_buffer_readdata),
        .emptylist_in_data(emptylist_in_data), .emptylist_in_valid(emptylist_in_valid),
        .emptylist_in_ready(emptylist_in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .out_empty(out_empty)
`ifdef DATA_MOVER_STATS_EN
        , .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pkt_flits [PKT_NUM];
    int exp_addr [$];
    int exp_el [$];
    flit_t exp_q [NUM_CH][$];
    int read_log [$];
    bit rand_mode = 1'b0;
    logic [NUM_CH-1:0] force_out_ready = '1;
    logic force_el_ready = 1'b1;
    int next_id = 100;

    task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Buffer contents as a pure function of the address and the packet's length.
    function automatic flit_t mem_flit(input int addr);
        flit_t f;
        int pid, idx;
        pid = addr / MAX_FLITS;
        idx = addr % MAX_FLITS;
        for (int k = 0; k < 16; k++) f.data[k*32 +: 32] = (32'(addr) * 32'h9E3779B1) ^ 32'(k << 20);
        f.sop = (idx == 0);
        f.eop = (idx == pkt_flits[pid] - 1);
        f.empty = f.eop ? 6'(pid) : 6'd0;
        return f;
    endfunction

    function automatic int pending();
        int n;
        n = exp_addr.size() + exp_el.size();
        for (int c = 0; c < NUM_CH; c++) n += exp_q[c].size();
        return n;
    endfunction

    task automatic flush_model();
        exp_addr.delete();
        exp_el.delete();
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready generators, updated just after each active edge.
    initial begin
        out_ready = '1;
        emptylist_in_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_mode ? NUM_CH'($urandom) : force_out_ready;
            emptylist_in_ready = rand_mode ? ($urandom_range(0, 3) != 0) : force_el_ready;
        end
    end

    // Packet buffer: fixed RD_LATENCY read pipe, cleared by reset.
    initial begin
        bit pv [RD_LATENCY+1];
        int pa [RD_LATENCY+1];
        for (int i = 0; i <= RD_LATENCY; i++) begin pv[i] = 1'b0; pa[i] = 0; end
        pkt_buffer_readvalid = 1'b0;
        pkt_buffer_readdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i <= RD_LATENCY; i++) pv[i] = 1'b0;
                pkt_buffer_readvalid = 1'b0;
                pkt_buffer_readdata = '0;
            end else begin
                for (int i = RD_LATENCY; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
                pv[0] = pkt_buffer_read;
                pa[0] = int'(pkt_buffer_address);
                pkt_buffer_readvalid = pv[RD_LATENCY];
                pkt_buffer_readdata = pv[RD_LATENCY] ? mem_flit(pa[RD_LATENCY]) : '0;
            end
        end
    end

    // Monitor: compares every read, output flit and emptylist push with the queues.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (pkt_buffer_read) begin
                read_log.push_back(cyc);
                if (exp_addr.size() == 0) chk("read_extra", exp_addr.size(), 1);
                else chk("read_addr", pkt_buffer_address, exp_addr.pop_front());
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    flit_t act;
                    act = {out_data[c*512 +: 512], out_sop[c], out_eop[c], out_empty[c*6 +: 6]};
                    if (exp_q[c].size() == 0) chk("ch_extra_flit", exp_q[c].size(), 1);
                    else chk("ch_flit", act, exp_q[c].pop_front());
                end
            end
            if (emptylist_in_valid && emptylist_in_ready) begin
                if (exp_el.size() == 0) chk("el_extra_push", exp_el.size(), 1);
                else chk("el_push", emptylist_in_data, exp_el.pop_front());
            end
        end
    end

    // All tasks below start and end just after an active clock edge.
    task automatic send_meta(input int pid, input int fl, input int dst, input bit drop);
        int n;
        bit ok;
        meta_valid = 1'b1;
        meta_pktid = PKT_AW'(pid);
        meta_flits = (FLIT_W+1)'(fl);
        meta_dst = DST_W'(dst);
        meta_drop = drop;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 5000) begin
            @(negedge clk);
            if (meta_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (ok) begin
            if (!drop) begin
                pkt_flits[pid] = fl;
                for (int i = 0; i < fl; i++) begin
                    exp_addr.push_back(pid * MAX_FLITS + i);
                    exp_q[dst].push_back(mem_flit(pid * MAX_FLITS + i));
                end
            end
            exp_el.push_back(pid);
            @(posedge clk);
            #1;
        end else begin
            chk("meta_accept_timeout", n, 0);
        end
        meta_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (pending() != 0 && n < limit) begin @(negedge clk); n++; end
        chk("drain_left", pending(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_meta_ready(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!meta_ready && n < limit) begin @(negedge clk); n++; end
        chk("meta_ready_after_init", meta_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_meta_ready"}, meta_ready, 0);
        chk({tag, "_read"}, pkt_buffer_read, 0);
        chk({tag, "_el_valid"}, emptylist_in_valid, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, n;
        rst_n = 1'b0;
        meta_valid = 1'b0; meta_pktid = '0; meta_flits = '0; meta_dst = '0; meta_drop = 1'b0;
        for (int i = 0; i < PKT_NUM; i++) pkt_flits[i] = 1;
        for (int i = 0; i < PKT_NUM; i++) exp_el.push_back(i);
        idle(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Emptylist initialisation: PKT_NUM pushes 0..PKT_NUM-1, then meta_ready.
        wait_meta_ready(INIT_WAIT + PKT_NUM + 100);
        chk("init_pushes_left", exp_el.size(), 0);

        // Single packet: pktid 3, 4 flits, channel 1, latency check.
        send_meta(3, 4, 1, 1'b0);
        n = 0;
        @(negedge clk);
        while (!pkt_buffer_read && n < 10) begin @(negedge clk); n++; end
        chk("read_delay_after_accept", n, 0);
        t0 = cyc;
        n = 0;
        while (!out_valid[1] && n < 40) begin @(negedge clk); n++; end
        t1 = cyc;
        chk("first_flit_latency", t1 - t0, RD_LATENCY + 1);
        @(posedge clk); #1;
        drain(200);

        // Back-to-back single-flit packets alternating channels.
        read_log.delete();
        for (int i = 0; i < 16; i++) send_meta(20 + i, 1, i % 2, 1'b0);
        drain(200);
        chk("b2b_read_count", read_log.size(), 16);
        if (read_log.size() == 16) chk("b2b_read_span", read_log[15] - read_log[0], 15);

        // Backpressure: channel 0 blocked, 20-flit packet.
        force_out_ready = 2'b10;
        idle(2);
        read_log.delete();
        send_meta(40, 20, 0, 1'b0);
        idle(60);
        chk("bp_reads_at_credit_limit", read_log.size(), OUT_DEPTH);
        chk("bp_flits_held", exp_q[0].size(), 20);
        force_out_ready = '1;
        drain(300);
        chk("bp_total_reads", read_log.size(), 20);

        // Drop with emptylist stalled for 5 cycles.
        force_el_ready = 1'b0;
        idle(2);
        send_meta(7, 1, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drop_el_valid_held", emptylist_in_valid, 1);
            chk("drop_el_data", emptylist_in_data, 7);
            chk("drop_meta_ready_low", meta_ready, 0);
            @(posedge clk); #1;
        end
        force_el_ready = 1'b1;
        drain(50);
        @(negedge clk);
        chk("drop_meta_ready_back", meta_ready, 1);
        @(posedge clk); #1;

        // Randomised traffic with random backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send_meta(next_id, $urandom_range(1, MAX_FLITS), $urandom_range(0, NUM_CH - 1),
                      ($urandom_range(0, 7) == 0));
            next_id = (next_id + 1) % PKT_NUM;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain(30000);
        rand_mode = 1'b0;
        idle(2);

        // Reset in the middle of a packet.
        send_meta(200, 20, 1, 1'b0);
        idle(5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        flush_model();
        idle(3);
        for (int i = 0; i < PKT_NUM; i++) exp_el.push_back(i);
        rst_n = 1'b1;
        wait_meta_ready(INIT_WAIT + PKT_NUM + 100);
        chk("reinit_pushes_left", exp_el.size(), 0);
        send_meta(5, 3, 0, 1'b0);
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
